// File: rtl/btn_pkg.sv
// btn_pkg: state encoding, event codes and parameter check shared by the button event decoder
package btn_pkg;

    typedef logic [2:0] state_t;

    localparam state_t IDLE     = 3'd0;
    localparam state_t PRESS1   = 3'd1;
    localparam state_t GAP      = 3'd2;
    localparam state_t HOLD     = 3'd3;
    localparam state_t WAIT_REL = 3'd4;

    localparam logic [1:0] EVT_SHORT  = 2'd0;
    localparam logic [1:0] EVT_DOUBLE = 2'd1;
    localparam logic [1:0] EVT_LONG   = 2'd2;
    localparam logic [1:0] EVT_REPEAT = 2'd3;

    // a cycle count is usable when it is at least 2 and its terminal value fits the counter
    function automatic bit cycles_ok(input int cycles, input int cnt_w);
        return cycles >= 2 && $clog2(longint'(cycles) + 1) <= cnt_w;
    endfunction

endpackage

// File: rtl/btn_event_decoder_if.sv
// btn_event_decoder_if: valid/ready event channel with sticky overflow flag
interface btn_event_decoder_if;

    logic       evt_valid;
    logic [1:0] evt_code;
    logic       evt_ready;
    logic       evt_ovf;

    modport master (
        output evt_valid,
        output evt_code,
        output evt_ovf,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_code,
        input  evt_ovf,
        output evt_ready
    );

endinterface

// File: rtl/btn_evt_buf.sv
// btn_evt_buf: one-entry event buffer that drops and flags events arriving while it is full
module btn_evt_buf (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  logic [1:0]          code,
    btn_event_decoder_if.master evt
);

    logic full_held;

    assign full_held = evt.evt_valid & ~evt.evt_ready;

    // accept when empty or being popped this cycle, otherwise keep the entry and flag the loss
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            evt.evt_valid <= 1'b0;
            evt.evt_code  <= 2'd0;
            evt.evt_ovf   <= 1'b0;
        end else begin
            evt.evt_valid <= push | full_held;
            evt.evt_code  <= (push & ~full_held) ? code : evt.evt_code;
            evt.evt_ovf   <= evt.evt_ovf | (push & full_held);
        end
    end

endmodule

// File: rtl/btn_event_decoder.sv
// btn_event_decoder: classifies a debounced button level into short/double/long/repeat events
module btn_event_decoder
    import btn_pkg::*;
#(
    parameter int CNT_W         = 27,
    parameter int LONG_CYCLES   = 100_000_000,
    parameter int GAP_CYCLES    = 30_000_000,
    parameter int REPEAT_CYCLES = 20_000_000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                btn_dbnc,
    output logic                pressed,
    btn_event_decoder_if.master evt
);

    if (!cycles_ok(LONG_CYCLES, CNT_W) || !cycles_ok(GAP_CYCLES, CNT_W) ||
        !cycles_ok(REPEAT_CYCLES, CNT_W)) begin : g_param_chk
        $error("btn_event_decoder: every *_CYCLES must be >= 2 and < 2**CNT_W");
    end

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    logic             btn_q;
    logic             armed;
    logic             rise;
    logic             fall;
    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             cnt_clr;
    logic             long_hit;
    logic             gap_hit;
    logic             rep_hit;
    logic             push;
    logic [1:0]       push_code;

    // armed marks that btn_q holds a real sample of a low level, so a button
    // already held when reset releases is not mistaken for a fresh press
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_q <= 1'b0;
            armed <= 1'b0;
        end else begin
            btn_q <= btn_dbnc;
            armed <= armed | ~btn_dbnc;
        end
    end

    assign pressed  = btn_q;
    assign rise     = btn_dbnc & ~btn_q & armed;
    assign fall     = ~btn_dbnc & btn_q;
    assign long_hit = cnt == LONG_LAST;
    assign gap_hit  = cnt == GAP_LAST;
    assign rep_hit  = cnt == REPEAT_LAST;

    // counter restarts on every state change and on each repeat; it rests at zero
    // in IDLE and WAIT_REL where no timeout applies, so it can never wrap
    assign cnt_clr = (state_nxt != state) || (state == HOLD && push) ||
                     state == IDLE || state == WAIT_REL;

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // shared cycle counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt <= '0;
        else     cnt <= cnt_clr ? '0 : cnt + 1'b1;
    end

    // next state; a release always wins over a timeout on the same edge
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     state_nxt = rise ? PRESS1 : IDLE;
            PRESS1:   state_nxt = fall ? GAP : (long_hit ? HOLD : PRESS1);
            GAP:      state_nxt = rise ? WAIT_REL : (gap_hit ? IDLE : GAP);
            HOLD:     state_nxt = fall ? IDLE : HOLD;
            WAIT_REL: state_nxt = fall ? IDLE : WAIT_REL;
            default:  state_nxt = IDLE;
        endcase
    end

    // event decision; a rise on the gap-expiry edge counts as a double click
    always_comb begin
        push      = 1'b0;
        push_code = EVT_SHORT;
        case (state)
            PRESS1: begin
                push      = ~fall & long_hit;
                push_code = EVT_LONG;
            end
            GAP: begin
                push      = rise | gap_hit;
                push_code = rise ? EVT_DOUBLE : EVT_SHORT;
            end
            HOLD: begin
                push      = ~fall & rep_hit;
                push_code = EVT_REPEAT;
            end
            default: ;
        endcase
    end

    btn_evt_buf u_buf (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .code (push_code),
        .evt  (evt)
    );

endmodule

// File: tb/tb_btn_event_decoder.sv
// tb_btn_event_decoder: vector table plus hand sequences, with a scoreboard of expected events
module tb_btn_event_decoder;
    import btn_pkg::*;

    typedef struct {
        logic       btn;
        logic       ready;
        logic       exp_valid;
        logic [1:0] exp_code;
        logic       exp_ovf;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_dbnc = 1'b0;
    logic       pressed;
    int         n_chk = 0;
    int         n_fail = 0;
    logic [1:0] sb[$];
    vec_t       vecs[$];

    btn_event_decoder_if evt_if();

    btn_event_decoder #(
        .CNT_W         (8),
        .LONG_CYCLES   (8),
        .GAP_CYCLES    (4),
        .REPEAT_CYCLES (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_dbnc (btn_dbnc),
        .pressed  (pressed),
        .evt      (evt_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string nm, input logic v, input logic [1:0] c, input logic o);
        chk({nm, "_valid"}, evt_if.evt_valid, v);
        if (v) chk({nm, "_code"}, evt_if.evt_code, c);
        chk({nm, "_ovf"}, evt_if.evt_ovf, o);
    endtask

    task automatic step(input logic b, input logic r);
        btn_dbnc = b;
        evt_if.evt_ready = r;
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic void add(input int n, input logic b, input logic ev = 1'b0,
                                input logic [1:0] code = 2'd0);
        for (int i = 0; i < n; i++) vecs.push_back('{b, 1'b1, ev, code, 1'b0});
    endfunction

    // every accepted event must match the oldest expected one
    always @(posedge clk) begin
        if (!rst && evt_if.evt_valid && evt_if.evt_ready) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL sb_extra: got event code %0d expected none", evt_if.evt_code);
            end else begin
                chk("sb_code", evt_if.evt_code, sb.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        evt_if.evt_ready = 1'b1;
        // short press: 3 high, SHORT on the 5th low cycle
        add(3, 1'b1); add(4, 1'b0); add(1, 1'b0, 1'b1, EVT_SHORT); add(2, 1'b0);
        // double click: 2 high, 2 low, DOUBLE on the second rise
        add(2, 1'b1); add(2, 1'b0); add(1, 1'b1, 1'b1, EVT_DOUBLE); add(1, 1'b1); add(6, 1'b0);
        // long press held 15 cycles: LONG after edge 8, REPEAT after 11 and 14
        add(8, 1'b1); add(1, 1'b1, 1'b1, EVT_LONG); add(2, 1'b1); add(1, 1'b1, 1'b1, EVT_REPEAT);
        add(2, 1'b1); add(1, 1'b1, 1'b1, EVT_REPEAT); add(5, 1'b0);
        #12;
        chk_out("reset", 1'b0, 2'd0, 1'b0);
        chk("reset_code", evt_if.evt_code, 0);
        chk("reset_pressed", pressed, 0);
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        foreach (vecs[i]) begin
            btn_dbnc = vecs[i].btn;
            evt_if.evt_ready = vecs[i].ready;
            if (vecs[i].exp_valid) sb.push_back(vecs[i].exp_code);
            @(posedge clk);
            @(negedge clk);
            chk_out($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_code, vecs[i].exp_ovf);
            chk($sformatf("vec%0d_pressed", i), pressed, vecs[i].btn);
        end
        // pop of a pending SHORT on the same edge a LONG is decided
        sb.push_back(EVT_SHORT);
        repeat (3) step(1'b1, 1'b0);
        repeat (5) step(1'b0, 1'b0);
        chk_out("pend_short", 1'b1, EVT_SHORT, 1'b0);
        sb.push_back(EVT_LONG);
        repeat (8) step(1'b1, 1'b0);
        chk_out("pend_held", 1'b1, EVT_SHORT, 1'b0);
        step(1'b1, 1'b1);
        chk_out("pop_emit", 1'b1, EVT_LONG, 1'b0);
        step(1'b0, 1'b1);
        chk_out("pop_emit_drain", 1'b0, 2'd0, 1'b0);
        // backpressure: SHORT held, DOUBLE dropped
        sb.push_back(EVT_SHORT);
        repeat (3) step(1'b1, 1'b0);
        repeat (5) step(1'b0, 1'b0);
        chk_out("bp_short", 1'b1, EVT_SHORT, 1'b0);
        repeat (2) step(1'b1, 1'b0);
        repeat (2) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        chk_out("bp_drop", 1'b1, EVT_SHORT, 1'b1);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk_out("bp_still", 1'b1, EVT_SHORT, 1'b1);
        step(1'b0, 1'b1);
        chk_out("bp_pop", 1'b0, 2'd0, 1'b1);
        // reset in the middle of a hold, button kept high afterwards
        repeat (5) step(1'b1, 1'b1);
        rst = 1'b1;
        #1;
        chk_out("mid_rst", 1'b0, 2'd0, 1'b0);
        chk("mid_rst_pressed", pressed, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1);
            chk_out($sformatf("post_rst%0d", i), 1'b0, 2'd0, 1'b0);
        end
        chk("post_rst_pressed", pressed, 1);
        repeat (2) step(1'b0, 1'b1);
        sb.push_back(EVT_SHORT);
        repeat (3) step(1'b1, 1'b1);
        repeat (4) step(1'b0, 1'b1);
        chk_out("rst_short_pre", 1'b0, 2'd0, 1'b0);
        step(1'b0, 1'b1);
        chk_out("rst_short", 1'b1, EVT_SHORT, 1'b0);
        step(1'b0, 1'b1);
        chk_out("rst_short_after", 1'b0, 2'd0, 1'b0);
        repeat (3) step(1'b0, 1'b1);
        chk("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
